// File: rtl/uart_tx_if.sv
// Byte handshake between a producer and the uart_tx holding buffer.
// The master presents data_in/data_valid. The slave returns data_ready.
interface uart_tx_if;
    logic [7:0] data_in;
    logic       data_valid;
    logic       data_ready;

    modport master (output data_in, output data_valid, input data_ready);
    modport slave  (input data_in, input data_valid, output data_ready);
endinterface

// File: rtl/uart_tx.sv
// 8N1 UART transmitter with a one-entry holding buffer.
// Each frame is one start bit (0), eight data bits sent LSB first, and one
// stop bit (1). Every bit is held for CLOCKS_PER_BIT clocks. A byte waiting
// in the buffer starts as soon as the current stop bit ends, so consecutive
// frames are sent without an idle gap.
module uart_tx #(
    parameter int CLOCKS_PER_BIT = 2605
) (
    input  logic     clock,
    input  logic     reset,
    uart_tx_if.slave bus,
    output logic     serial_out,
    output logic     busy,
    output logic     frame_done
);

    localparam int CNT_W = (CLOCKS_PER_BIT > 1) ? $clog2(CLOCKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLOCKS_PER_BIT - 1);

    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_START = 2'b01;
    localparam logic [1:0] ST_DATA  = 2'b10;
    localparam logic [1:0] ST_STOP  = 2'b11;

    logic [1:0]       state;
    logic [CNT_W-1:0] clk_cnt;
    logic [2:0]       bit_idx;
    logic             buf_empty;
    logic [7:0]       buf_data;
    logic [7:0]       shift;

    logic bit_last;
    logic accept;
    logic drain;

    assign bit_last = (clk_cnt == CNT_LAST);
    assign accept   = buf_empty && bus.data_valid;
    // A full buffer is loaded into the shift register on the edge where the
    // FSM enters START: either from IDLE, or at the end of a stop bit.
    assign drain    = !buf_empty &&
                      ((state == ST_IDLE) || ((state == ST_STOP) && bit_last));

    assign bus.data_ready = buf_empty;
    assign busy           = (state != ST_IDLE) || !buf_empty;
    assign frame_done     = (state == ST_STOP) && bit_last;

    // Byte storage: buffer capture on accept, shift register load on drain and shift after each data bit.
    always_ff @(posedge clock) begin
        if (accept) begin
            buf_data <= bus.data_in;
        end
        if (drain) begin
            shift <= buf_data;
        end else if ((state == ST_DATA) && bit_last) begin
            shift <= shift >> 1;
        end
    end

    // Frame sequencing, bit timing, buffer occupancy and the registered line output.
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= ST_IDLE;
            clk_cnt    <= '0;
            bit_idx    <= '0;
            buf_empty  <= 1'b1;
            serial_out <= 1'b1;
        end else begin
            if (accept) begin
                buf_empty <= 1'b0;
            end else if (drain) begin
                buf_empty <= 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    clk_cnt    <= '0;
                    bit_idx    <= '0;
                    serial_out <= 1'b1;
                    if (!buf_empty) begin
                        state      <= ST_START;
                        serial_out <= 1'b0;
                    end
                end
                ST_START: begin
                    if (bit_last) begin
                        clk_cnt    <= '0;
                        bit_idx    <= '0;
                        state      <= ST_DATA;
                        serial_out <= shift[0];
                    end else begin
                        clk_cnt <= clk_cnt + CNT_W'(1);
                    end
                end
                ST_DATA: begin
                    if (bit_last) begin
                        clk_cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            state      <= ST_STOP;
                            serial_out <= 1'b1;
                        end else begin
                            bit_idx    <= bit_idx + 3'd1;
                            serial_out <= shift[1];
                        end
                    end else begin
                        clk_cnt <= clk_cnt + CNT_W'(1);
                    end
                end
                ST_STOP: begin
                    if (bit_last) begin
                        clk_cnt <= '0;
                        if (!buf_empty) begin
                            state      <= ST_START;
                            serial_out <= 1'b0;
                        end else begin
                            state      <= ST_IDLE;
                            serial_out <= 1'b1;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state      <= ST_IDLE;
                    clk_cnt    <= '0;
                    bit_idx    <= '0;
                    buf_empty  <= 1'b1;
                    serial_out <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx.
// u_small uses a short bit time for the directed and random frame checks.
// u_def uses the default bit time and feeds a behavioural receiver.
module tb_uart_tx;

    localparam int CPB     = 16;
    localparam int CPB_DEF = 2605;

    logic clock   = 1'b0;
    logic reset   = 1'b1;
    logic reset_d = 1'b1;

    always #5 clock = ~clock;

    uart_tx_if bus_s ();
    uart_tx_if bus_d ();

    logic so_s, busy_s, fd_s;
    logic so_d, busy_d, fd_d;

    uart_tx #(.CLOCKS_PER_BIT(CPB)) u_small (
        .clock      (clock),
        .reset      (reset),
        .bus        (bus_s),
        .serial_out (so_s),
        .busy       (busy_s),
        .frame_done (fd_s)
    );

    uart_tx u_def (
        .clock      (clock),
        .reset      (reset_d),
        .bus        (bus_d),
        .serial_out (so_d),
        .busy       (busy_d),
        .frame_done (fd_d)
    );

    int          vectors     = 0;
    int          miscompares = 0;
    int unsigned cyc_all     = 0;
    logic        rst_at_edge = 1'b1;

    logic [7:0] exp_s[$];
    logic [7:0] exp_d[$];
    int         rx_cnt_d = 0;

    always @(posedge clock) begin
        cyc_all     <= cyc_all + 1;
        rst_at_edge <= reset;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc_all);
        end
    endtask

    // Line model for u_small: every cycle of a frame must carry the level
    // implied by the expected byte, and frame_done must coincide with the
    // final cycle of the stop bit only.
    bit         in_frame = 1'b0;
    int         fcyc     = 0;
    logic [7:0] cur_byte = 8'h00;

    initial begin
        int   b;
        logic lvl;
        forever begin
            @(negedge clock);
            if (rst_at_edge) begin
                check("rst_serial_out", so_s, 1);
                check("rst_busy", busy_s, 0);
                check("rst_data_ready", bus_s.data_ready, 1);
                check("rst_frame_done", fd_s, 0);
                in_frame = 1'b0;
            end else begin
                if (!in_frame && so_s === 1'b0) begin
                    in_frame = 1'b1;
                    fcyc     = 0;
                    if (exp_s.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL unexpected_frame: got a start bit, expected none pending (cycle %0d)", cyc_all);
                        cur_byte = 8'h00;
                    end else begin
                        cur_byte = exp_s.pop_front();
                    end
                end
                if (in_frame) begin
                    fcyc++;
                    b = (fcyc - 1) / CPB;
                    if (b == 0)      lvl = 1'b0;
                    else if (b == 9) lvl = 1'b1;
                    else             lvl = cur_byte[b-1];
                    check("line_bit", so_s, lvl);
                    check("busy_in_frame", busy_s, 1);
                    check("frame_done", fd_s, (fcyc == 10 * CPB) ? 1 : 0);
                    if (fcyc == 10 * CPB) in_frame = 1'b0;
                end else begin
                    check("idle_frame_done", fd_s, 0);
                end
            end
        end
    end

    // Behavioural receiver on u_def: finds the start edge, samples mid-bit.
    initial begin
        logic [7:0] output_stream;
        logic [7:0] e;
        forever begin
            @(negedge clock);
            if (!reset_d && so_d === 1'b0) begin
                repeat (CPB_DEF / 2) @(negedge clock);
                check("loop_start_bit", so_d, 0);
                for (int k = 0; k < 8; k++) begin
                    repeat (CPB_DEF) @(negedge clock);
                    output_stream[k] = so_d;
                end
                repeat (CPB_DEF) @(negedge clock);
                check("loop_stop_bit", so_d, 1);
                e = (exp_d.size() != 0) ? exp_d.pop_front() : 8'hxx;
                check("loop_output_stream", output_stream, e);
                rx_cnt_d++;
            end
        end
    end

    task automatic send_s(input logic [7:0] b, output int waited);
        waited = 0;
        bus_s.data_valid = 1'b1;
        while (bus_s.data_ready !== 1'b1 && waited < 2000) begin
            bus_s.data_in = 8'($urandom);
            @(negedge clock);
            waited++;
        end
        if (waited >= 2000) begin
            check("send_s_timeout", bus_s.data_ready, 1);
        end else begin
            bus_s.data_in = b;
            exp_s.push_back(b);
            @(negedge clock);
        end
    endtask

    task automatic send_d(input logic [7:0] b);
        int waited = 0;
        bus_d.data_valid = 1'b1;
        bus_d.data_in    = b;
        while (bus_d.data_ready !== 1'b1 && waited < 30000) begin
            @(negedge clock);
            waited++;
        end
        if (waited >= 30000) begin
            check("send_d_timeout", bus_d.data_ready, 1);
        end else begin
            exp_d.push_back(b);
            @(negedge clock);
        end
    endtask

    task automatic wait_fd(output int unsigned t);
        int n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (fd_s !== 1'b1 && n < 1000);
        if (n >= 1000) check("wait_frame_done_timeout", fd_s, 1);
        t = cyc_all;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy_s !== 1'b0 && n < 2000) begin
            @(negedge clock);
            n++;
        end
        if (n >= 2000) check("wait_idle_timeout", busy_s, 0);
        @(negedge clock);
    endtask

    task automatic seq_small();
        int          w;
        int unsigned t0, t1, t2;
        logic [7:0]  b;
        bus_s.data_valid = 1'b0;
        bus_s.data_in    = 8'h00;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        repeat (2) @(negedge clock);

        // Single byte from idle: one-cycle latency to the start bit.
        send_s(8'hA5, w);
        bus_s.data_valid = 1'b0;
        check("lat_line_still_high", so_s, 1);
        check("lat_ready_low", bus_s.data_ready, 0);
        check("lat_busy", busy_s, 1);
        @(negedge clock);
        t0 = cyc_all;
        check("start_bit_low", so_s, 0);
        check("ready_after_drain", bus_s.data_ready, 1);
        wait_fd(t1);
        check("single_fd_cycle", t1 - t0, 159);
        wait_idle();

        // Back-to-back: second byte handed over while the first is in START.
        send_s(8'h00, w);
        bus_s.data_valid = 1'b0;
        @(negedge clock);
        t0 = cyc_all;
        check("b2b_start_low", so_s, 0);
        check("b2b_ready", bus_s.data_ready, 1);
        send_s(8'hFF, w);
        bus_s.data_valid = 1'b0;
        check("b2b_immediate", w, 0);
        wait_fd(t1);
        check("b2b_fd1_cycle", t1 - t0, 159);
        wait_fd(t2);
        check("b2b_fd2_cycle", t2 - t0, 319);
        wait_idle();

        // Backpressure: data_valid held high for three bytes.
        send_s(8'($urandom), w);
        check("bp_first_wait", w, 0);
        send_s(8'($urandom), w);
        check("bp_second_wait", w, 1);
        send_s(8'($urandom), w);
        check("bp_third_wait", w, 159);
        bus_s.data_valid = 1'b0;
        wait_idle();

        // Reset during data bit 3 of 0x3C, with data_valid raised alongside.
        send_s(8'h3C, w);
        bus_s.data_valid = 1'b0;
        @(negedge clock);
        repeat (4 * CPB + 4) @(negedge clock);
        reset            = 1'b1;
        bus_s.data_valid = 1'b1;
        bus_s.data_in    = 8'h77;
        @(negedge clock);
        check("midrst_serial_out", so_s, 1);
        check("midrst_busy", busy_s, 0);
        check("midrst_ready", bus_s.data_ready, 1);
        reset            = 1'b0;
        bus_s.data_valid = 1'b0;
        @(negedge clock);
        check("rst_wins_busy", busy_s, 0);
        check("rst_wins_ready", bus_s.data_ready, 1);
        send_s(8'($urandom), w);
        bus_s.data_valid = 1'b0;
        wait_fd(t1);
        wait_idle();

        // Random bytes with random gaps and occasional held data_valid.
        for (int i = 0; i < 16; i++) begin
            b = 8'($urandom);
            send_s(b, w);
            if ($urandom_range(0, 1) == 1) begin
                bus_s.data_valid = 1'b0;
                repeat ($urandom_range(0, 40)) @(negedge clock);
            end
        end
        bus_s.data_valid = 1'b0;
        wait_idle();

        // Idle hold.
        for (int i = 0; i < 10000; i++) begin
            @(negedge clock);
            if (i % 50 == 0) begin
                check("idle_busy", busy_s, 0);
                check("idle_line", so_s, 1);
            end
        end
    endtask

    task automatic seq_def();
        int n = 0;
        bus_d.data_valid = 1'b0;
        bus_d.data_in    = 8'h00;
        repeat (3) @(negedge clock);
        reset_d = 1'b0;
        repeat (2) @(negedge clock);
        send_d(8'h3C);
        send_d(8'hC3);
        bus_d.data_valid = 1'b0;
        while (rx_cnt_d < 2 && n < 60000) begin
            @(negedge clock);
            n++;
        end
        if (n >= 60000) check("loop_rx_timeout", rx_cnt_d, 2);
        repeat (CPB_DEF) @(negedge clock);
        check("loop_idle_busy", busy_d, 0);
    endtask

    initial begin
        fork
            seq_small();
            seq_def();
        join
        check("small_queue_empty", exp_s.size(), 0);
        check("def_queue_empty", exp_d.size(), 0);
        check("def_rx_count", rx_cnt_d, 2);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not complete, miscompares %0d", miscompares);
        $fatal(1);
    end

endmodule
